// File: rtl/modexp_ctrl_if.sv
// rtl/modexp_ctrl_if.sv - Montgomery multiplier start/operand/result handshake bundle
//
// Purpose: groups the signals between the modexp controller (master) and the
//          Montgomery multiplier (slave).
// Ports (signals):
//   mm_start   master->slave  1-cycle start pulse
//   mm_a/mm_b  master->slave  operands, stable from mm_start until mm_done
//   mm_m       master->slave  modulus
//   mm_result  slave->master  product a*b*R^-1 mod m, valid with mm_done
//   mm_done    slave->master  completion pulse
interface modexp_ctrl_if #(
    parameter int DATA_W = 1024
);
    logic              mm_start;
    logic [DATA_W-1:0] mm_a;
    logic [DATA_W-1:0] mm_b;
    logic [DATA_W-1:0] mm_m;
    logic [DATA_W-1:0] mm_result;
    logic              mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right binary modular exponentiation controller
//
// Purpose: result = in_x^in_e mod in_m using an external Montgomery multiplier.
//          Operands are in normal form; conversion into the Montgomery domain
//          (x*R via MM(x, R^2)) and back out (MM(acc, 1)) happens internally.
// Configuration macro: MODEXP_CONST_TIME_EN - when defined, a multiply step runs
//          for every exponent bit and its product is discarded on 0-bits.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              1-cycle request, sampled only in IDLE
//   in_x, in_e, e_len  base, exponent, number of exponent bits to process
//   in_m, in_r, in_r2  odd modulus, R mod M, R^2 mod M
//   result, done, busy final value, completion pulse, job in progress
//   mm                 multiplier interface (master side)
module modexp_ctrl #(
    parameter int DATA_W = 1024,
    parameter int EXP_W  = 1024,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [EXP_W-1:0]  in_e,
    input  logic [LEN_W-1:0]  e_len,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_r2,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    modexp_ctrl_if.master     mm
);

    typedef enum logic [3:0] {
        IDLE,
        XT_START,
        XT_WAIT,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        NEXT,
        POST_START,
        POST_WAIT,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATA_W-1:0] xReg;
    logic [DATA_W-1:0] rReg;
    logic [DATA_W-1:0] r2Reg;
    logic [DATA_W-1:0] mReg;
    logic [DATA_W-1:0] xtReg;
    logic [DATA_W-1:0] accReg;
    // Exponent left-aligned so the bit to process next is always the MSB.
    logic [EXP_W-1:0]  eReg;
    logic [LEN_W-1:0]  idx;
`ifdef MODEXP_CONST_TIME_EN
    logic              keepProduct;
`endif

    assign mm.mm_m = mReg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        done        = 1'b0;
        busy        = 1'b0;
        mm.mm_start = 1'b0;
        mm.mm_a     = '0;
        mm.mm_b     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = XT_START;
                end
            end
            XT_START: begin
                busy        = 1'b1;
                mm.mm_start = 1'b1;
                mm.mm_a     = xReg;
                mm.mm_b     = r2Reg;
                stateNext   = XT_WAIT;
            end
            XT_WAIT: begin
                busy    = 1'b1;
                mm.mm_a = xReg;
                mm.mm_b = r2Reg;
                if (mm.mm_done) begin
                    stateNext = (idx == '0) ? POST_START : SQ_START;
                end
            end
            SQ_START: begin
                busy        = 1'b1;
                mm.mm_start = 1'b1;
                mm.mm_a     = accReg;
                mm.mm_b     = accReg;
                stateNext   = SQ_WAIT;
            end
            SQ_WAIT: begin
                busy    = 1'b1;
                mm.mm_a = accReg;
                mm.mm_b = accReg;
                if (mm.mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
                    stateNext = MUL_START;
`else
                    stateNext = eReg[EXP_W-1] ? MUL_START : NEXT;
`endif
                end
            end
            MUL_START: begin
                busy        = 1'b1;
                mm.mm_start = 1'b1;
                mm.mm_a     = accReg;
                mm.mm_b     = xtReg;
                stateNext   = MUL_WAIT;
            end
            MUL_WAIT: begin
                busy    = 1'b1;
                mm.mm_a = accReg;
                mm.mm_b = xtReg;
                if (mm.mm_done) begin
                    stateNext = NEXT;
                end
            end
            NEXT: begin
                busy      = 1'b1;
                stateNext = (idx == '0) ? POST_START : SQ_START;
            end
            POST_START: begin
                busy        = 1'b1;
                mm.mm_start = 1'b1;
                mm.mm_a     = accReg;
                mm.mm_b     = DATA_W'(1);
                stateNext   = POST_WAIT;
            end
            POST_WAIT: begin
                busy    = 1'b1;
                mm.mm_a = accReg;
                mm.mm_b = DATA_W'(1);
                if (mm.mm_done) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xReg        <= '0;
            rReg        <= '0;
            r2Reg       <= '0;
            mReg        <= '0;
            xtReg       <= '0;
            accReg      <= '0;
            eReg        <= '0;
            idx         <= '0;
            result      <= '0;
`ifdef MODEXP_CONST_TIME_EN
            keepProduct <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xReg  <= in_x;
                        rReg  <= in_r;
                        r2Reg <= in_r2;
                        mReg  <= in_m;
                        // Shifting out the unused upper bits makes bits >= e_len irrelevant.
                        eReg  <= in_e << (LEN_W'(EXP_W) - e_len);
                        idx   <= e_len;
                    end
                end
                XT_WAIT: begin
                    if (mm.mm_done) begin
                        xtReg  <= mm.mm_result;
                        accReg <= rReg;
                    end
                end
                SQ_WAIT: begin
                    if (mm.mm_done) begin
                        accReg <= mm.mm_result;
                        idx    <= idx - LEN_W'(1);
                        eReg   <= eReg << 1;
`ifdef MODEXP_CONST_TIME_EN
                        keepProduct <= eReg[EXP_W-1];
`endif
                    end
                end
                MUL_WAIT: begin
                    if (mm.mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
                        if (keepProduct) begin
                            accReg <= mm.mm_result;
                        end
`else
                        accReg <= mm.mm_result;
`endif
                    end
                end
                POST_WAIT: begin
                    if (mm.mm_done) begin
                        // Loaded here so result is valid in the same cycle as done.
                        accReg <= mm.mm_result;
                        result <= mm.mm_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - directed self-checking bench for modexp_ctrl with a Montgomery multiplier model
module tb_modexp_ctrl;
    localparam int DW = 1024;
    localparam int EW = 1024;
    localparam int LW = 11;

`ifdef MODEXP_CONST_TIME_EN
    localparam int T1_STARTS = 8;
    localparam int T4_STARTS = 36;
`else
    localparam int T1_STARTS = 7;
    localparam int T4_STARTS = 21;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [DW-1:0] in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic [LW-1:0] e_len;
    logic [DW-1:0] result;
    logic          done, busy;

    modexp_ctrl_if #(.DATA_W(DW)) mmIf ();

    modexp_ctrl #(.DATA_W(DW), .EXP_W(EW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .e_len(e_len), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy), .mm(mmIf)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    // ---------------- golden arithmetic ----------------
    function automatic logic [DW-1:0] rmod(input logic [DW-1:0] m, input int n);
        logic [DW:0] v;
        v = 1;
        for (int i = 0; i < n; i++) begin
            v = v << 1;
            if (v >= {1'b0, m}) v = v - {1'b0, m};
        end
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mont(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m);
        logic [DW+1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m);
        logic [DW:0] acc;
        acc = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            acc = acc << 1;
            if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
            if (b[i]) begin
                acc = acc + {1'b0, a};
                if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
            end
        end
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] powmod(input logic [DW-1:0] x, input logic [EW-1:0] e, input int len, input logic [DW-1:0] m);
        logic [DW-1:0] res;
        res = 1;
        for (int i = len - 1; i >= 0; i--) begin
            res = mulmod(res, res, m);
            if (e[i]) res = mulmod(res, x, m);
        end
        return res;
    endfunction

    // ---------------- multiplier model ----------------
    int            mmLat = 0;
    logic          spurious = 1'b0;
    int            startCount = 0;
    int            doneCount = 0;
    int            stabErr = 0;
    logic          pending = 1'b0;
    int            cnt = 0;
    logic [DW-1:0] pa, pb, pres;

    always @(posedge clk) begin
        #1;
        mmIf.mm_done = 1'b0;
        if (done) doneCount++;
        if (!resetn) begin
            pending = 1'b0;
            cnt = 0;
        end else begin
            if (pending) begin
                if (mmIf.mm_a !== pa || mmIf.mm_b !== pb) stabErr++;
                if (cnt == 0) begin
                    mmIf.mm_done   = 1'b1;
                    mmIf.mm_result = pres;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mmIf.mm_start) begin
                pa = mmIf.mm_a;
                pb = mmIf.mm_b;
                pres = mont(pa, pb, mmIf.mm_m);
                cnt = mmLat;
                pending = 1'b1;
                startCount++;
                if (spurious) begin
                    mmIf.mm_done   = 1'b1;
                    mmIf.mm_result = ~pres;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStart(input logic [DW-1:0] x, input logic [EW-1:0] e, input logic [LW-1:0] len, input logic [DW-1:0] m);
        @(negedge clk);
        in_x = x; in_e = e; e_len = len; in_m = m;
        in_r = rmod(m, DW); in_r2 = rmod(m, 2 * DW);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output logic timedOut, output logic [DW-1:0] res, output int busyErr, output int cycles);
        timedOut = 1'b1; res = '0; busyErr = 0; cycles = 0;
        for (int c = 0; c < 5000; c++) begin
            if (done) begin
                timedOut = 1'b0; res = result; cycles = c;
                break;
            end
            if (!busy) busyErr++;
            @(negedge clk);
        end
    endtask

    task automatic runJob(input logic [DW-1:0] x, input logic [EW-1:0] e, input logic [LW-1:0] len, input logic [DW-1:0] m,
                          output logic timedOut, output logic [DW-1:0] res, output int busyErr,
                          output int nStarts, output int nDones, output int cycles, output int nStab);
        int s0, d0, b0;
        s0 = startCount; d0 = doneCount; b0 = stabErr;
        applyStart(x, e, len, m);
        waitDone(timedOut, res, busyErr, cycles);
        repeat (3) @(negedge clk);
        nStarts = startCount - s0; nDones = doneCount - d0; nStab = stabErr - b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_e = '0; e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(negedge clk);
        totalCnt++; if (result !== '0) $display("FAIL reset_result got=%0h exp=0", result[63:0]); else passCnt++;
        totalCnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (mmIf.mm_start !== 1'b0) $display("FAIL reset_mm_start got=%b exp=0", mmIf.mm_start); else passCnt++;
        totalCnt++; if (mmIf.mm_a !== '0 || mmIf.mm_b !== '0 || mmIf.mm_m !== '0)
            $display("FAIL reset_mm_operands got a=%0h b=%0h m=%0h exp=0", mmIf.mm_a[63:0], mmIf.mm_b[63:0], mmIf.mm_m[63:0]); else passCnt++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic to; logic [DW-1:0] res; int be, ns, nd, cy, st;
        mmLat = 0;
        runJob(DW'(3), EW'(5), LW'(3), DW'(241), to, res, be, ns, nd, cy, st);
        totalCnt++; if (to !== 1'b0) $display("FAIL basic_timeout got=%b exp=0", to); else passCnt++;
        totalCnt++; if (res !== DW'(2)) $display("FAIL basic_result got=%0h exp=2", res[63:0]); else passCnt++;
        totalCnt++; if (ns !== T1_STARTS) $display("FAIL basic_mm_starts got=%0d exp=%0d", ns, T1_STARTS); else passCnt++;
        totalCnt++; if (nd !== 1) $display("FAIL basic_done_pulses got=%0d exp=1", nd); else passCnt++;
        totalCnt++; if (cy !== 2 * T1_STARTS + 3) $display("FAIL basic_latency got=%0d exp=%0d", cy, 2 * T1_STARTS + 3); else passCnt++;
        totalCnt++; if (be !== 0) $display("FAIL basic_busy_drops got=%0d exp=0", be); else passCnt++;
        totalCnt++; if (result !== DW'(2)) $display("FAIL basic_result_held got=%0h exp=2", result[63:0]); else passCnt++;
    endtask

    task automatic test_elen_zero;
        logic to; logic [DW-1:0] res; int be, ns, nd, cy, st;
        mmLat = 1;
        runJob(DW'(200), '1, LW'(0), DW'(241), to, res, be, ns, nd, cy, st);
        totalCnt++; if (to !== 1'b0) $display("FAIL elen0_timeout got=%b exp=0", to); else passCnt++;
        totalCnt++; if (res !== DW'(1)) $display("FAIL elen0_result got=%0h exp=1", res[63:0]); else passCnt++;
        totalCnt++; if (ns !== 2) $display("FAIL elen0_mm_starts got=%0d exp=2", ns); else passCnt++;
        totalCnt++; if (cy !== 6) $display("FAIL elen0_latency got=%0d exp=6", cy); else passCnt++;
    endtask

    task automatic test_upper_bits;
        logic to; logic [DW-1:0] res; int be, ns, nd, cy, st;
        logic [EW-1:0] e;
        mmLat = 0;
        e = '1; e[3:0] = 4'h1;
        runJob(DW'(7), e, LW'(1), DW'(241), to, res, be, ns, nd, cy, st);
        totalCnt++; if (res !== DW'(7)) $display("FAIL upper_bits_result got=%0h exp=7", res[63:0]); else passCnt++;
        totalCnt++; if (ns !== 4) $display("FAIL upper_bits_mm_starts got=%0d exp=4", ns); else passCnt++;
    endtask

    task automatic test_random_1024;
        logic to; logic [DW-1:0] res, m, x, exp; int be, ns, nd, cy, st;
        for (int i = 0; i < DW / 32; i++) begin
            m[i*32 +: 32] = $urandom;
            x[i*32 +: 32] = $urandom;
        end
        m[DW-1] = 1'b1; m[0] = 1'b1; x[DW-1] = 1'b0;
        exp = powmod(x, EW'(32'h10001), 17, m);
        mmLat = 2; spurious = 1'b1;
        runJob(x, EW'(32'h10001), LW'(17), m, to, res, be, ns, nd, cy, st);
        spurious = 1'b0;
        totalCnt++; if (to !== 1'b0) $display("FAIL rand_timeout got=%b exp=0", to); else passCnt++;
        totalCnt++; if (res !== exp) $display("FAIL rand_result got[127:0]=%0h exp[127:0]=%0h", res[127:0], exp[127:0]); else passCnt++;
        totalCnt++; if (be !== 0) $display("FAIL rand_busy_drops got=%0d exp=0", be); else passCnt++;
        totalCnt++; if (st !== 0) $display("FAIL rand_operand_unstable got=%0d exp=0", st); else passCnt++;
        totalCnt++; if (ns !== T4_STARTS) $display("FAIL rand_mm_starts got=%0d exp=%0d", ns, T4_STARTS); else passCnt++;
        totalCnt++; if (cy !== 4 * T4_STARTS + 17) $display("FAIL rand_latency got=%0d exp=%0d", cy, 4 * T4_STARTS + 17); else passCnt++;
    endtask

    task automatic test_restart_ignored;
        logic to; logic [DW-1:0] res; int be, cy, s0, d0;
        mmLat = 1;
        s0 = startCount; d0 = doneCount;
        applyStart(DW'(3), EW'(5), LW'(3), DW'(241));
        repeat (4) @(negedge clk);
        in_x = DW'(10); in_e = EW'(7); e_len = LW'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(to, res, be, cy);
        repeat (3) @(negedge clk);
        totalCnt++; if (res !== DW'(2)) $display("FAIL restart_result got=%0h exp=2", res[63:0]); else passCnt++;
        totalCnt++; if (startCount - s0 !== T1_STARTS) $display("FAIL restart_mm_starts got=%0d exp=%0d", startCount - s0, T1_STARTS); else passCnt++;
        totalCnt++; if (doneCount - d0 !== 1) $display("FAIL restart_done_pulses got=%0d exp=1", doneCount - d0); else passCnt++;
    endtask

    task automatic test_reset_mid;
        logic to; logic [DW-1:0] res; int be, ns, nd, cy, st, s0, d0;
        logic reached;
        mmLat = 6;
        s0 = startCount; d0 = doneCount; reached = 1'b0;
        applyStart(DW'(3), EW'(5), LW'(3), DW'(241));
        for (int c = 0; c < 200; c++) begin
            if (startCount - s0 >= 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        totalCnt++; if (reached !== 1'b1) $display("FAIL mid_reach_sq_wait got=%b exp=1", reached); else passCnt++;
        resetn = 1'b0;
        #1;
        totalCnt++; if (result !== '0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset_outputs got result=%0h done=%b busy=%b exp=0", result[63:0], done, busy); else passCnt++;
        totalCnt++; if (mmIf.mm_start !== 1'b0 || mmIf.mm_a !== '0 || mmIf.mm_b !== '0 || mmIf.mm_m !== '0)
            $display("FAIL mid_reset_mm got start=%b a=%0h b=%0h m=%0h exp=0", mmIf.mm_start, mmIf.mm_a[63:0], mmIf.mm_b[63:0], mmIf.mm_m[63:0]); else passCnt++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mmLat = 0;
        runJob(DW'(3), EW'(5), LW'(3), DW'(241), to, res, be, ns, nd, cy, st);
        totalCnt++; if (res !== DW'(2)) $display("FAIL mid_rerun_result got=%0h exp=2", res[63:0]); else passCnt++;
        totalCnt++; if (ns !== T1_STARTS) $display("FAIL mid_rerun_mm_starts got=%0d exp=%0d", ns, T1_STARTS); else passCnt++;
        totalCnt++; if (doneCount - d0 !== 1) $display("FAIL mid_abort_done_pulses got=%0d exp=1", doneCount - d0); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_elen_zero();
        test_upper_bits();
        test_random_1024();
        test_restart_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
